// File: rtl/tdm_demux_8_if.sv
// Serial-in / word-out bundle for the 8-slot TDM receiver.
// The master side drives the serial stream; the slave side is the demux.
interface tdm_demux_8_if;
    logic       din;
    logic       din_valid;
    logic       sof;
    logic [7:0] out;
    logic       out_valid;
    logic       frame_err;
    logic [2:0] sel;
    logic       busy;

    modport master (
        output din, din_valid, sof,
        input  out, out_valid, frame_err, sel, busy
    );

    modport slave (
        input  din, din_valid, sof,
        output out, out_valid, frame_err, sel, busy
    );
endinterface

// File: rtl/tdm_demux_8.sv
// 8-slot TDM demultiplexer: gathers one serial bit per slot and emits the
// rebuilt byte with a one-cycle strobe. Gaps and early sof abort the frame.
module tdm_demux_8 #(
    parameter int unsigned GAP_MAX = 15
) (
    input  logic           clk,
    input  logic           rst,
    tdm_demux_8_if.slave   bus
);
    localparam int unsigned GW = $clog2(GAP_MAX + 1);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_COLLECT = 1'b1
    } state_t;

    state_t          r_state;
    logic [7:0]      r_shadow;
    logic [2:0]      r_sel;
    logic [GW-1:0]   r_gap;
    logic [7:0]      r_out;
    logic            r_out_valid;
    logic            r_frame_err;

    state_t          w_state_nxt;
    logic [7:0]      w_shadow_nxt;
    logic [2:0]      w_sel_nxt;
    logic [GW-1:0]   w_gap_nxt;
    logic [7:0]      w_out_nxt;
    logic            w_out_valid_nxt;
    logic            w_frame_err_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_shadow    <= 8'h00;
            r_sel       <= 3'd0;
            r_gap       <= '0;
            r_out       <= 8'h00;
            r_out_valid <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_shadow    <= w_shadow_nxt;
            r_sel       <= w_sel_nxt;
            r_gap       <= w_gap_nxt;
            r_out       <= w_out_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    // Next-state and next-output logic; strobes default low every cycle.
    always_comb begin
        w_state_nxt     = r_state;
        w_shadow_nxt    = r_shadow;
        w_sel_nxt       = r_sel;
        w_gap_nxt       = r_gap;
        w_out_nxt       = r_out;
        w_out_valid_nxt = 1'b0;
        w_frame_err_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.din_valid && bus.sof) begin
                    w_shadow_nxt = {7'b0, bus.din};
                    w_sel_nxt    = 3'd1;
                    w_gap_nxt    = '0;
                    w_state_nxt  = S_COLLECT;
                end
            end

            S_COLLECT: begin
                if (bus.din_valid) begin
                    w_gap_nxt = '0;
                    if (bus.sof) begin
                        // Early sof: drop the partial frame, restart at slot 0.
                        w_frame_err_nxt = 1'b1;
                        w_shadow_nxt    = {7'b0, bus.din};
                        w_sel_nxt       = 3'd1;
                    end else begin
                        w_shadow_nxt[r_sel] = bus.din;
                        if (r_sel == 3'd7) begin
                            w_out_nxt       = {bus.din, r_shadow[6:0]};
                            w_out_valid_nxt = 1'b1;
                            w_sel_nxt       = 3'd0;
                            w_state_nxt     = S_IDLE;
                        end else begin
                            w_sel_nxt = r_sel + 3'd1;
                        end
                    end
                end else if (r_gap == GW'(GAP_MAX)) begin
                    w_frame_err_nxt = 1'b1;
                    w_sel_nxt       = 3'd0;
                    w_gap_nxt       = '0;
                    w_state_nxt     = S_IDLE;
                end else begin
                    w_gap_nxt = r_gap + GW'(1);
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.out       = r_out;
    assign bus.out_valid = r_out_valid;
    assign bus.frame_err = r_frame_err;
    assign bus.sel       = r_sel;
    assign bus.busy      = (r_state == S_COLLECT);

endmodule

// File: tb/tb_tdm_demux_8.sv
// Bench for tdm_demux_8: directed table, hand-built corner sequences and a
// random stream, all checked against a queue-based frame model.
module tb_tdm_demux_8;
    localparam int unsigned GAP = 15;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   cnt_ov;
    int   cnt_err;

    tdm_demux_8_if bus ();

    tdm_demux_8 #(.GAP_MAX(GAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: frame = queue of received bits, slot index = queue length.
    bit         m_active;
    bit         m_q[$];
    int         m_idle;
    logic [7:0] m_out;
    logic       m_ov;
    logic       m_err;
    logic [2:0] m_sel;
    logic       m_busy;

    function automatic void model_reset();
        m_active = 0;
        m_q.delete();
        m_idle = 0;
        m_out  = 8'h00;
        m_ov   = 1'b0;
        m_err  = 1'b0;
        m_sel  = 3'd0;
        m_busy = 1'b0;
    endfunction

    function automatic void model_step(input logic v, input logic s, input logic d);
        m_ov  = 1'b0;
        m_err = 1'b0;
        if (!m_active) begin
            if (v && s) begin
                m_active = 1;
                m_q.delete();
                m_q.push_back(d);
                m_idle = 0;
            end
        end else if (v) begin
            m_idle = 0;
            if (s) begin
                m_err = 1'b1;
                m_q.delete();
                m_q.push_back(d);
            end else begin
                m_q.push_back(d);
                if (m_q.size() == 8) begin
                    for (int k = 0; k < 8; k++) m_out[k] = m_q[k];
                    m_ov = 1'b1;
                    m_active = 0;
                    m_q.delete();
                end
            end
        end else begin
            m_idle++;
            if (m_idle > int'(GAP)) begin
                m_err = 1'b1;
                m_active = 0;
                m_q.delete();
            end
        end
        m_sel  = m_active ? 3'(m_q.size()) : 3'd0;
        m_busy = m_active;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [13:0] dut_vec();
        return {bus.out, bus.out_valid, bus.frame_err, bus.sel, bus.busy};
    endfunction

    // One clock: drive at negedge, sample at the following negedge.
    task automatic step(input logic v, input logic s, input logic d);
        bus.din_valid = v;
        bus.sof       = s;
        bus.din       = d;
        @(posedge clk);
        @(negedge clk);
        model_step(v, s, d);
        if (bus.out_valid) cnt_ov++;
        if (bus.frame_err) cnt_err++;
        check("model", 32'(dut_vec()), 32'({m_out, m_ov, m_err, m_sel, m_busy}));
    endtask

    task automatic send_slots(input logic [7:0] w, input int lo, input int hi);
        for (int k = lo; k <= hi; k++) step(1'b1, k == 0, w[k]);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic       v, s, d;
        logic [7:0] out;
        logic       ov, err;
        logic [2:0] sel;
        logic       busy;
    } vec_t;
    vec_t tbl[$];

    function automatic void add_frame(input logic [7:0] w, input logic [7:0] prev);
        vec_t r;
        for (int k = 0; k < 8; k++) begin
            r.v = 1'b1; r.s = (k == 0); r.d = w[k];
            r.err = 1'b0;
            if (k < 7) begin
                r.out = prev; r.ov = 1'b0; r.sel = 3'(k + 1); r.busy = 1'b1;
            end else begin
                r.out = w;    r.ov = 1'b1; r.sel = 3'd0;      r.busy = 1'b0;
            end
            tbl.push_back(r);
        end
    endfunction

    function automatic void add_idle(input logic [7:0] cur, input logic d);
        vec_t r;
        r.v = 1'b0; r.s = 1'b0; r.d = d;
        r.out = cur; r.ov = 1'b0; r.err = 1'b0; r.sel = 3'd0; r.busy = 1'b0;
        tbl.push_back(r);
    endfunction

    function automatic void add_ignored(input logic [7:0] cur);
        vec_t r;
        r.v = 1'b1; r.s = 1'b0; r.d = 1'b1;
        r.out = cur; r.ov = 1'b0; r.err = 1'b0; r.sel = 3'd0; r.busy = 1'b0;
        tbl.push_back(r);
    endfunction

    initial begin
        int ov0;
        int err0;
        n_checks = 0; n_fail = 0; cnt_ov = 0; cnt_err = 0;
        bus.din = 1'b0; bus.din_valid = 1'b0; bus.sof = 1'b0;
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        check("reset_state", 32'(dut_vec()), 32'(14'h0));
        rst = 1'b0;

        // Directed table: single frame, stray valid bits, back-to-back frames.
        add_frame(8'hB6, 8'h00);
        add_idle(8'hB6, 1'b1);
        add_ignored(8'hB6);
        add_frame(8'hB6, 8'hB6);
        add_frame(8'h49, 8'hB6);
        add_idle(8'h49, 1'b0);
        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].s, tbl[i].d);
            check("table", 32'(dut_vec()),
                  32'({tbl[i].out, tbl[i].ov, tbl[i].err, tbl[i].sel, tbl[i].busy}));
        end

        // 3-cycle gap after slot 4: completion delayed, no error.
        err0 = cnt_err; ov0 = cnt_ov;
        send_slots(8'hB6, 0, 4);
        idle(3);
        check("gap3_busy", 32'(bus.busy), 32'd1);
        send_slots(8'hB6, 5, 6);
        check("gap3_no_ov_early", 32'(cnt_ov - ov0), 32'd0);
        send_slots(8'hB6, 7, 7);
        check("gap3_ov", 32'(bus.out_valid), 32'd1);
        check("gap3_out", 32'(bus.out), 32'hB6);
        check("gap3_no_err", 32'(cnt_err - err0), 32'd0);

        // Early sof at slot 5 becomes slot 0 of an all-ones frame.
        err0 = cnt_err; ov0 = cnt_ov;
        send_slots(8'hB6, 0, 4);
        step(1'b1, 1'b1, 1'b1);
        check("presof_err", 32'(bus.frame_err), 32'd1);
        check("presof_sel", 32'(bus.sel), 32'd1);
        send_slots(8'hFF, 1, 6);
        check("presof_out_held", 32'(bus.out), 32'hB6);
        send_slots(8'hFF, 7, 7);
        check("presof_out_ff", 32'(bus.out), 32'hFF);
        check("presof_err_cnt", 32'(cnt_err - err0), 32'd1);
        check("presof_ov_cnt", 32'(cnt_ov - ov0), 32'd1);

        // sof coincident with slot 7 is an early sof.
        send_slots(8'h5A, 0, 6);
        step(1'b1, 1'b1, 1'b0);
        check("sof_at_7_err", 32'(bus.frame_err), 32'd1);
        check("sof_at_7_ov", 32'(bus.out_valid), 32'd0);
        send_slots(8'hB6, 1, 7);
        check("sof_at_7_out", 32'(bus.out), 32'hB6);

        // Gap timeout: GAP idle cycles tolerated, one more aborts.
        send_slots(8'h3C, 0, 2);
        idle(int'(GAP));
        check("gap_edge_busy", 32'(bus.busy), 32'd1);
        check("gap_edge_err", 32'(bus.frame_err), 32'd0);
        idle(1);
        check("gap_to_err", 32'(bus.frame_err), 32'd1);
        check("gap_to_busy", 32'(bus.busy), 32'd0);
        check("gap_to_sel", 32'(bus.sel), 32'd0);
        check("gap_to_out", 32'(bus.out), 32'hB6);
        idle(1);
        check("gap_to_pulse", 32'(bus.frame_err), 32'd0);

        // Asynchronous reset mid-frame.
        ov0 = cnt_ov; err0 = cnt_err;
        send_slots(8'hB6, 0, 3);
        bus.din_valid = 1'b0; bus.sof = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("async_rst", 32'(dut_vec()), 32'(14'h0));
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_no_strobe", 32'((cnt_ov - ov0) + (cnt_err - err0)), 32'd0);
        send_slots(8'hC3, 0, 7);
        check("post_rst_out", 32'(bus.out), 32'hC3);
        check("post_rst_ov", 32'(bus.out_valid), 32'd1);

        // Random stream against the model.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) < 3) begin
                idle(int'($urandom_range(10, 20)));
            end else begin
                step(($urandom_range(0, 4) != 0), ($urandom_range(0, 11) == 0),
                     1'($urandom_range(0, 1)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tdm_demux_8.md
# tdm_demux_8

Receive-side companion to the 8:1 time-division multiplexer. It accepts one serial bit per slot while an internal slot index counts 0..7, and writes each bit to output lane `out[slot]`. After all eight slots are captured it presents the reconstructed 8-bit word with a one-cycle valid strobe. It sits at the far end of the serial link, after the select-driven 8:1 mux.

## Interface
Parameters:
- `GAP_MAX`, default 15: maximum consecutive idle cycles (`din_valid` low) allowed inside a frame before the frame is aborted. Legal range 1..255.

Ports:
- `clk`  input  1  single system clock; all logic is rising-edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `din`  input  1  serial data bit for the current slot.
- `din_valid`  input  1  `din` is valid this cycle.
- `sof`  input  1  start of frame; qualified by `din_valid`; marks slot 0.
- `out`  output  8  last completed word; `out[k]` holds slot k.
- `out_valid`  output  1  one-cycle strobe: `out` was updated this cycle.
- `frame_err`  output  1  one-cycle strobe: the current frame was aborted.
- `sel`  output  3  slot index expected next (debug/monitor).
- `busy`  output  1  high while in state COLLECT.

## Operation
- State machine has two states: IDLE and COLLECT.
- Internal registers:
  - `shadow[7:0]`: per-slot capture register.
  - `gap_cnt`: idle-cycle counter, width ceil(log2(GAP_MAX+1)).
- In IDLE, on `din_valid & sof`:
  - `shadow[0] <= din`, `sel <= 1`, `gap_cnt <= 0`, go to COLLECT.
- In IDLE, `din_valid` without `sof` is ignored: no capture, no error.
- In COLLECT, on `din_valid & ~sof`:
  - `shadow[sel] <= din`, `gap_cnt <= 0`, `sel <= sel+1` (wraps 7 to 0).
- In COLLECT, capturing slot 7 completes the frame:
  - `out <= {din, shadow[6:0]}`, `out_valid <= 1`, `sel <= 0`, go to IDLE.
- In COLLECT, on `din_valid & sof` (premature start of frame):
  - `frame_err <= 1` and the partial frame is discarded.
  - That same bit is taken as slot 0 of a new frame: `shadow[0] <= din`, `sel <= 1`, stay in COLLECT.
- In COLLECT, `din_valid` low increments `gap_cnt`.
  - When `gap_cnt` would exceed `GAP_MAX`: `frame_err <= 1`, `sel <= 0`, go to IDLE.
- An aborted frame never updates `out`; `out` holds the last good word.
- `busy` = (state == COLLECT).

## Timing
- Reset values:
  - `out` = 8'h00, `out_valid` = 0, `frame_err` = 0, `sel` = 0, `busy` = 0.
  - State = IDLE, `shadow` = 0, `gap_cnt` = 0.
- All outputs are registered; there are no combinational input-to-output paths.
- Latency: `out` and `out_valid` change on the same rising edge that samples slot 7. `out_valid` is high for exactly that one following cycle.
- Minimum frame is 8 cycles (`sof` on slot 0, `din_valid` held high). Back-to-back frames are allowed:
  - The cycle after completion, the block is in IDLE and accepts `sof`.
  - `sof` arriving in the same cycle as slot 7 is treated as a premature `sof`: error, restart.
- `out_valid` and `frame_err` are never asserted in the same cycle.
- Asserting `rst` mid-frame immediately discards the partial frame and clears `out`. No strobe is issued.
- Gap timeout: with the last valid bit at edge N and `din_valid` low afterwards, `frame_err` pulses after edge N+GAP_MAX+1.

## Test plan
- Reset, then send frame 8'b10110110 LSB-first with `sof` on slot 0 and `din_valid` continuously high (`din` sequence 0,1,1,0,1,1,0,1).
  - Required: `out` = 8'hB6, a single `out_valid` pulse 8 cycles after the `sof` cycle, `busy` falling the same cycle.
- Same frame with a 3-cycle `din_valid`-low gap after slot 4 (GAP_MAX=15).
  - Required: `out` = 8'hB6, `out_valid` delayed by 3 cycles, no `frame_err`.
- Two back-to-back frames 8'hB6 then 8'h49 with no idle cycle between them.
  - Required: two `out_valid` pulses exactly 8 cycles apart, with `out` = B6 then 49.
- Frame 8'hB6 with a new `sof` at slot 5, followed by a full frame 8'hFF.
  - Required: one `frame_err` pulse, `out` stays B6 until the FF frame completes, then `out` = FF. No `out_valid` for the aborted frame.
- Start a frame, then hold `din_valid` low for GAP_MAX+1 cycles after slot 2.
  - Required: `frame_err` pulse, `busy` = 0, `sel` = 0, `out` unchanged.
- Assert `rst` for 1 cycle after slot 3.
  - Required: all outputs return to their reset values asynchronously, no strobe, and the next full frame decodes correctly.
